// File: rtl/bist_fault_sequencer_if.sv
// rtl/bist_fault_sequencer_if.sv - signal bundle between the fault sequencer and its test controller / ALU wrapper
// master is the sequencer side; slave is the controller/ALU side.
interface bist_fault_sequencer_if #(
    parameter int NSITES = 12
);
    localparam int CW = $clog2(2*NSITES+1);

    logic                  start;
    logic                  ut_e;
    logic                  ut_reset;
    logic                  ut_enable;
    logic [NSITES-1:0]     check;
    logic                  value;
    logic                  busy;
    logic                  done;
    logic                  golden_fail;
    logic [2*NSITES-1:0]   detected;
    logic [CW-1:0]         det_count;

    modport master (
        input  start, ut_e,
        output ut_reset, ut_enable, check, value, busy, done, golden_fail, detected, det_count
    );

    modport slave (
        output start, ut_e,
        input  ut_reset, ut_enable, check, value, busy, done, golden_fail, detected, det_count
    );
endinterface

// File: rtl/bist_fault_sequencer.sv
// rtl/bist_fault_sequencer.sv - stuck-at fault-injection campaign sequencer for the BIST-wrapped ALU
// One golden pass, then one RST+RUN slot per (site, stuck value); all outputs registered.
module bist_fault_sequencer #(
    parameter int NSITES = 12,
    parameter int PCYC   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    bist_fault_sequencer_if.master          bus
);
    localparam int NF = 2*NSITES;
    localparam int KW = $clog2(NF);
    localparam int CW = $clog2(NF+1);

    typedef enum logic [2:0] {
        S_IDLE, S_G_RST, S_G_RUN, S_F_RST, S_F_RUN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [NF-1:0]     detected_q, detected_d;
    logic [CW-1:0]     det_count_q, det_count_d;
    logic              golden_fail_q, golden_fail_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ut_reset_q, ut_reset_d;
    logic              ut_enable_q, ut_enable_d;
    logic [NSITES-1:0] check_q, check_d;
    logic              value_q, value_d;

    logic              run_hit;
    logic              last_cyc;
    logic              in_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            detected_q    <= '0;
            det_count_q   <= '0;
            golden_fail_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            ut_reset_q    <= 1'b0;
            ut_enable_q   <= 1'b0;
            check_q       <= '0;
            value_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            detected_q    <= detected_d;
            det_count_q   <= det_count_d;
            golden_fail_q <= golden_fail_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            ut_reset_q    <= ut_reset_d;
            ut_enable_q   <= ut_enable_d;
            check_q       <= check_d;
            value_q       <= value_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        detected_d    = detected_q;
        det_count_d   = det_count_q;
        golden_fail_d = golden_fail_q;
        done_d        = done_q;
        // err_q holds the OR of earlier RUN samples; this edge's sample is folded in here
        run_hit       = err_q | bus.ut_e;
        last_cyc      = (cnt_q == 8'(PCYC-1));

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d       = S_G_RST;
                    k_d           = '0;
                    detected_d    = '0;
                    det_count_d   = '0;
                    done_d        = 1'b0;
                    golden_fail_d = 1'b0;
                end
            end
            S_G_RST: begin
                state_d = S_G_RUN;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            S_G_RUN: begin
                err_d = run_hit;
                cnt_d = cnt_q + 8'd1;
                if (last_cyc) begin
                    if (run_hit) begin
                        golden_fail_d = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        k_d     = '0;
                        state_d = S_F_RST;
                    end
                end
            end
            S_F_RST: begin
                state_d = S_F_RUN;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            S_F_RUN: begin
                err_d = run_hit;
                cnt_d = cnt_q + 8'd1;
                if (last_cyc) begin
                    if (run_hit && !detected_q[k_q]) begin
                        detected_d[k_q] = 1'b1;
                        det_count_d     = det_count_q + CW'(1);
                    end
                    if (k_q == KW'(NF-1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_F_RST;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with the state they describe
        in_fault    = (state_d == S_F_RST) || (state_d == S_F_RUN);
        ut_reset_d  = (state_d == S_G_RST) || (state_d == S_F_RST);
        ut_enable_d = (state_d == S_G_RUN) || (state_d == S_F_RUN);
        busy_d      = (state_d == S_G_RST) || (state_d == S_G_RUN) || in_fault;
        check_d     = in_fault ? (NSITES'(1) << (k_d >> 1)) : '0;
        value_d     = in_fault & k_d[0];
    end

    assign bus.ut_reset    = ut_reset_q;
    assign bus.ut_enable   = ut_enable_q;
    assign bus.check       = check_q;
    assign bus.value       = value_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.golden_fail = golden_fail_q;
    assign bus.detected    = detected_q;
    assign bus.det_count   = det_count_q;
endmodule

// File: doc/bist_fault_sequencer.md
# bist_fault_sequencer

Sequencer that runs a complete stuck-at fault-injection campaign on the BIST-wrapped ALU. It drives the ALU's test reset, enable, fault-select one-hot and stuck value, then observes its error flag. It runs one fault-free golden pass, then one pass per (site, stuck value) pair, and records which faults were detected. It sits between the test bench or top-level test controller and the ALU BIST wrapper, replacing hand-written fault sequences.

## Interface
- NSITES, 12, number of injectable fault sites; width of the fault-select one-hot.
- PCYC, 8, run cycles per pass (pattern window). Legal range is 1 to 255.
- clk  in  1  rising-edge clock shared with the ALU wrapper.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  campaign request; sampled only in IDLE.
- ut_e  in  1  ALU error flag (faulty output differs from golden).
- ut_reset  out  1  reset pulse to the ALU pattern generator.
- ut_enable  out  1  enable to the ALU pattern generator.
- check  out  NSITES  fault-select one-hot; all zero means fault-free.
- value  out  1  stuck-at value for the selected site.
- busy  out  1  campaign in progress.
- done  out  1  campaign finished; held until next accepted start or reset.
- golden_fail  out  1  error seen during the fault-free pass.
- detected  out  2*NSITES  bit k set means fault k was detected.
- det_count  out  clog2(2*NSITES+1)  population count of detected.

## Operation
- Fault index k runs from 0 to 2*NSITES-1.
  - site = k/2, so check = 1<<(k/2).
  - value = k%2. Even k is stuck-at-0; odd k is stuck-at-1.
- States and transitions:
  - IDLE: on start=1, go to G_RST. Clear detected, det_count, done and golden_fail.
  - G_RST: check=0, value=0. Lasts 1 cycle, then G_RUN.
  - G_RUN: check=0, value=0. Lasts PCYC cycles.
    - If ut_e was seen high in any G_RUN cycle, set golden_fail and go to DONE.
    - Otherwise go to F_RST with k=0.
  - F_RST: check and value for fault k. Lasts 1 cycle, then F_RUN.
  - F_RUN: check and value for fault k. Lasts PCYC cycles.
    - If ut_e was seen high in any F_RUN cycle, set detected[k] and increment det_count, exactly once per k.
    - If k was the last index, go to DONE. Otherwise increment k and go to F_RST.
  - DONE: 1 cycle. Set done=1, busy=0, return outputs to idle values, then go to IDLE.
- ut_reset = 1 exactly in G_RST and F_RST.
- ut_enable = 1 in G_RUN and F_RUN only.
- check and value are stable through each whole RST+RUN slot. They change only on slot boundaries.
- ut_e is sampled on every rising edge that ends a RUN cycle. Detection is the OR over those samples; it need not be sticky at the ALU.
- busy = 1 from the cycle after start is accepted through the last RUN cycle.
- start is ignored while busy or while in DONE.
- A new start after done restarts the full campaign.
- All outputs are registered.

## Timing
- Reset values: all outputs 0, state IDLE, k=0.
- Reset mid-campaign: on the next edge all outputs are 0 and state is IDLE. No partial results are retained.
- start is accepted at edge T. G_RST is active in cycle T+1.
- Slot length is 1+PCYC cycles.
- Full campaign: busy lasts (2*NSITES+1)*(1+PCYC) cycles, which is 225 for the defaults. done rises on the following edge.
- Golden abort: done rises (1+PCYC)+1 cycles after acceptance. check never leaves 0 and detected stays 0.
- Counter widths:
  - The slot counter counts 0 to PCYC-1 and resets on each RST.
  - The k counter wraps only via DONE and never exceeds 2*NSITES-1.
  - det_count saturates at 2*NSITES by construction.
- reset and start asserted in the same cycle: reset wins.

## Test plan
- Bench ALU model with every fault detectable; pulse start -> busy for 225 cycles, done=1, detected=24'hFFFFFF, det_count=24, golden_fail=0.
- Model where site 3 stuck-at-0 is masked -> detected=24'hFFFFBF (bit 6 clear), det_count=23.
- Force ut_e=1 during G_RUN -> golden_fail=1, done rises 10 cycles after acceptance, check stays 0 throughout, detected=0.
- Monitor every slot of a full run:
  - check=1<<(k/2) and value=k%2.
  - ut_reset high only in the first cycle of each 9-cycle slot.
  - ut_enable high in the other 8 cycles.
- Assert reset at cycle 100 of a campaign -> next cycle all outputs are 0. A later start runs a full 225-cycle campaign with correct results.
- Hold start=1 for the entire run -> campaign restarts only after DONE. A second campaign clears detected in its first cycle, and a pulse during busy has no effect.
